// File: rtl/railway_crossing_ctrl_v2.sv
// Multi-crossing level-crossing controller: one FSM per crossing with occupancy counting,
// barrier feedback timeout and sensor fail-safe. Define BARRIER_FB_CHECK_EN to use barrier feedback.
module railway_crossing_ctrl_v2 #(
  parameter int unsigned NUM_CROSSINGS   = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned OCC_W           = 3,
  parameter int unsigned WARN_CYCLES     = 50,
  parameter int unsigned TICK_CYCLES     = 16,
  parameter int unsigned COUNTDOWN_TICKS = 10,
  parameter int unsigned LOWER_CYCLES    = 20,
  parameter int unsigned BARRIER_TIMEOUT = 64,
  parameter int unsigned CLEAR_HOLD      = 8,
  parameter int unsigned BLINK_BIT       = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CROSSINGS-1:0]         train_detected,
  input  logic [NUM_CROSSINGS-1:0]         train_exited,
  input  logic                             emergency_global,
  input  logic [1:0]                       weather_mode,
  input  logic [NUM_CROSSINGS-1:0]         sensor_health,
  input  logic [NUM_CROSSINGS-1:0]         barrier_down_fb,
  input  logic [NUM_CROSSINGS-1:0]         maint_req,
  output logic [NUM_CROSSINGS-1:0]         barrier_down,
  output logic [NUM_CROSSINGS-1:0]         red_light,
  output logic [NUM_CROSSINGS-1:0]         yellow_light,
  output logic [NUM_CROSSINGS-1:0]         alarm_sound,
  output logic [3*NUM_CROSSINGS-1:0]       crossing_states,
  output logic [OCC_W*NUM_CROSSINGS-1:0]   occupancy,
  output logic [NUM_CROSSINGS-1:0]         barrier_faults,
  output logic [NUM_CROSSINGS-1:0]         sensor_faults
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWarning   = 3'd1,
    StCountdown = 3'd2,
    StLowering  = 3'd3,
    StTrainPass = 3'd4,
    StClearing  = 3'd5,
    StEmergency = 3'd6,
    StFault     = 3'd7
  } state_e;

  localparam int unsigned TickW = $clog2(TICK_CYCLES + 1);
  localparam int unsigned CdW   = $clog2(COUNTDOWN_TICKS + 1);
  localparam int unsigned ExtW  = CNT_W + 3;

  localparam logic [OCC_W-1:0] OccMax = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NUM_CROSSINGS-1:0] det_q, exit_q, det_rise, exit_rise;
  logic [ExtW-1:0]          warn_thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q  <= '0;
      exit_q <= '0;
    end else begin
      det_q  <= train_detected;
      exit_q <= train_exited;
    end
  end

  assign det_rise  = train_detected & ~det_q;
  assign exit_rise = train_exited & ~exit_q;
  assign warn_thr  = ExtW'(WARN_CYCLES) << weather_mode;

`ifndef BARRIER_FB_CHECK_EN
  logic unused_fb;
  assign unused_fb = ^barrier_down_fb;
`endif

  for (genvar j = 0; j < NUM_CROSSINGS; j++) begin : gen_xing
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dwell_q;
    logic [ExtW-1:0]  dwell_p1;
    logic [TickW-1:0] tick_q;
    logic [CdW-1:0]   cd_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             sfault_q, sens_trip, fault_clr, tick_wrap;
    logic             bar_o, red_o, yel_o, alm_o, blink;

    // Cycles spent in the current state including this one.
    assign dwell_p1  = {3'b000, dwell_q} + ExtW'(1);
    assign tick_wrap = (tick_q == TickW'(TICK_CYCLES - 1));
    assign sens_trip = !emergency_global && !sensor_health[j] &&
                       (state_q != StEmergency) && (state_q != StFault);
    assign fault_clr = (state_q == StFault) && (state_d == StIdle);

    always_comb begin
      occ_d = occ_q;
      if (det_rise[j] && !exit_rise[j]) begin
        if (occ_q != OccMax) occ_d = occ_q + OCC_W'(1);
      end else if (exit_rise[j] && !det_rise[j]) begin
        if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
      end
    end

    always_comb begin
      state_d = state_q;
      if (emergency_global) begin
        state_d = StEmergency;
      end else if (sens_trip) begin
        state_d = StFault;
      end else begin
        unique case (state_q)
          StIdle: if (occ_q != '0 || det_rise[j]) state_d = StWarning;
          StWarning: if (dwell_p1 >= warn_thr) state_d = StCountdown;
          StCountdown: if (cd_q == '0 || (tick_wrap && cd_q == CdW'(1))) state_d = StLowering;
          StLowering: begin
`ifdef BARRIER_FB_CHECK_EN
            if (barrier_down_fb[j] && dwell_p1 >= ExtW'(LOWER_CYCLES)) state_d = StTrainPass;
            else if (dwell_p1 >= ExtW'(BARRIER_TIMEOUT)) state_d = StFault;
`else
            if (dwell_p1 >= ExtW'(LOWER_CYCLES)) state_d = StTrainPass;
`endif
          end
          StTrainPass: if (occ_q == '0) state_d = StClearing;
          StClearing: begin
            if (det_rise[j] || occ_q != '0) state_d = StTrainPass;
            else if (dwell_p1 >= ExtW'(CLEAR_HOLD)) state_d = StIdle;
          end
          StEmergency: state_d = (occ_q != '0) ? StLowering : StIdle;
          StFault: if (maint_req[j] && sensor_health[j] && occ_q == '0) state_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= StIdle;
        dwell_q  <= '0;
        tick_q   <= '0;
        cd_q     <= '0;
        occ_q    <= '0;
        sfault_q <= 1'b0;
      end else begin
        state_q <= state_d;
        occ_q   <= occ_d;
        if (state_d != state_q) dwell_q <= '0;
        else if (dwell_q != CntMax) dwell_q <= dwell_q + CNT_W'(1);
        if (state_d == StCountdown && state_q != StCountdown) begin
          cd_q   <= CdW'(COUNTDOWN_TICKS);
          tick_q <= '0;
        end else if (state_q == StCountdown) begin
          if (tick_wrap) begin
            tick_q <= '0;
            if (cd_q != '0) cd_q <= cd_q - CdW'(1);
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
        if (fault_clr) sfault_q <= 1'b0;
        else if (sens_trip) sfault_q <= 1'b1;
      end
    end

`ifdef BARRIER_FB_CHECK_EN
    logic bfault_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bfault_q <= 1'b0;
      end else if (fault_clr) begin
        bfault_q <= 1'b0;
      end else if (state_q == StLowering && state_d == StFault && !sens_trip) begin
        bfault_q <= 1'b1;
      end
    end
    assign barrier_faults[j] = bfault_q;
`else
    assign barrier_faults[j] = 1'b0;
`endif

    assign blink = dwell_q[BLINK_BIT];

    always_comb begin
      bar_o = 1'b0;
      red_o = 1'b0;
      yel_o = 1'b0;
      alm_o = 1'b0;
      unique case (state_q)
        StIdle: ;
        StWarning: begin
          yel_o = 1'b1;
          alm_o = blink;
        end
        StCountdown: begin
          red_o = 1'b1;
          alm_o = blink;
        end
        StLowering: begin
          bar_o = 1'b1;
          red_o = 1'b1;
          alm_o = 1'b1;
        end
        StTrainPass, StClearing: begin
          bar_o = 1'b1;
          red_o = 1'b1;
        end
        StEmergency: begin
          red_o = 1'b1;
          yel_o = blink;
          alm_o = 1'b1;
        end
        StFault: begin
          bar_o = 1'b1;
          red_o = 1'b1;
          yel_o = blink;
          alm_o = 1'b1;
        end
      endcase
    end

    assign barrier_down[j]                   = bar_o;
    assign red_light[j]                      = red_o;
    assign yellow_light[j]                   = yel_o;
    assign alarm_sound[j]                    = alm_o;
    assign crossing_states[3*j +: 3]         = state_q;
    assign occupancy[OCC_W*j +: OCC_W]       = occ_q;
    assign sensor_faults[j]                  = sfault_q;
  end

endmodule

// File: tb/tb_railway_crossing_ctrl_v2.sv
// Scoreboard bench for railway_crossing_ctrl_v2: expected values are queued with the stimulus
// and popped when the matching DUT observation is taken.
module tb_railway_crossing_ctrl_v2;
  localparam int N     = 4;
  localparam int OCC_W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       train_detected, train_exited, sensor_health, barrier_down_fb, maint_req;
  logic               emergency_global;
  logic [1:0]         weather_mode;
  logic [N-1:0]       barrier_down, red_light, yellow_light, alarm_sound;
  logic [3*N-1:0]     crossing_states;
  logic [OCC_W*N-1:0] occupancy;
  logic [N-1:0]       barrier_faults, sensor_faults;

  railway_crossing_ctrl_v2 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .train_detected   (train_detected),
    .train_exited     (train_exited),
    .emergency_global (emergency_global),
    .weather_mode     (weather_mode),
    .sensor_health    (sensor_health),
    .barrier_down_fb  (barrier_down_fb),
    .maint_req        (maint_req),
    .barrier_down     (barrier_down),
    .red_light        (red_light),
    .yellow_light     (yellow_light),
    .alarm_sound      (alarm_sound),
    .crossing_states  (crossing_states),
    .occupancy        (occupancy),
    .barrier_faults   (barrier_faults),
    .sensor_faults    (sensor_faults)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
    else e = exp_q.pop_front();
    check_eq(tag, obs, e);
  endtask

  function automatic logic [2:0] st(input int j);
    return crossing_states[3*j +: 3];
  endfunction

  function automatic logic [OCC_W-1:0] occ(input int j);
    return occupancy[OCC_W*j +: OCC_W];
  endfunction

  task automatic wait_state(input int j, input logic [2:0] s, input int budget, input string tag);
    int k = 0;
    while (st(j) !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (st(j) !== s) check_eq({tag, "_timeout"}, 32'(st(j)), 32'(s));
  endtask

  task automatic dwell(input int j, input logic [2:0] s, output int cnt);
    cnt = 0;
    while (st(j) === s && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_det(input int j);
    train_detected[j] = 1'b1;
    @(negedge clk);
    train_detected[j] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_exit(input int j);
    train_exited[j] = 1'b1;
    @(negedge clk);
    train_exited[j] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    train_detected   = '0;
    train_exited     = '0;
    emergency_global = 1'b0;
    maint_req        = '0;
    sensor_health    = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    train_detected   = '0;
    train_exited     = '0;
    emergency_global = 1'b0;
    weather_mode     = 2'd0;
    sensor_health    = '1;
    barrier_down_fb  = '1;
    maint_req        = '0;
    repeat (2) @(negedge clk);

    sb_push(0); sb_check("rst_states", 32'(crossing_states));
    sb_push(0); sb_check("rst_occ", 32'(occupancy));
    sb_push(0); sb_check("rst_outputs", 32'({barrier_down, red_light, yellow_light, alarm_sound}));
    sb_push(0); sb_check("rst_faults", 32'({barrier_faults, sensor_faults}));
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal pass on crossing 0, weather x1.
    sb_push(1);
    train_detected[0] = 1'b1;
    @(negedge clk);
    sb_check("s1_warn_state", 32'(st(0)));
    sb_push(4'b0010);
    sb_check("s1_warn_out", 32'({barrier_down[0], red_light[0], yellow_light[0], alarm_sound[0]}));
    sb_push(50);  dwell(0, 3'd1, n); sb_check("s1_warn_len", n);
    sb_push(2);   sb_check("s1_cd_state", 32'(st(0)));
    sb_push(4'b0100);
    sb_check("s1_cd_out", 32'({barrier_down[0], red_light[0], yellow_light[0], alarm_sound[0]}));
    sb_push(160); dwell(0, 3'd2, n); sb_check("s1_cd_len", n);
    sb_push(3);   sb_check("s1_low_state", 32'(st(0)));
    sb_push(20);  dwell(0, 3'd3, n); sb_check("s1_low_len", n);
    sb_push(4);   sb_check("s1_tp_state", 32'(st(0)));
    sb_push(4'b1100);
    sb_check("s1_tp_out", 32'({barrier_down[0], red_light[0], yellow_light[0], alarm_sound[0]}));
    sb_push(1);   sb_check("s1_occ", 32'(occ(0)));
    train_detected[0] = 1'b0;
    pulse_exit(0);
    wait_state(0, 3'd5, 10, "s1_clr");
    sb_push(8);   dwell(0, 3'd5, n); sb_check("s1_clr_len", n);
    sb_push(0);   sb_check("s1_idle_state", 32'(st(0)));
    sb_push(0);   sb_check("s1_idle_out", 32'({barrier_down, red_light, yellow_light, alarm_sound}));
    sb_push(0);   sb_check("s1_idle_occ", 32'(occ(0)));

    // Weather scaling, with an async reset landing mid-countdown.
    do_reset();
    weather_mode = 2'd3;
    sb_push(1);
    train_detected[1] = 1'b1;
    @(negedge clk);
    sb_check("s2_warn_state", 32'(st(1)));
    sb_push(400); dwell(1, 3'd1, n); sb_check("s2_warn_len_x8", n);
    #2 rst_n = 1'b0;
    #1;
    sb_push(0); sb_check("s2_async_states", 32'(crossing_states));
    sb_push(0); sb_check("s2_async_occ", 32'(occupancy));
    sb_push(0); sb_check("s2_async_out", 32'({barrier_down, red_light}));
    train_detected = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    weather_mode = 2'd1;
    sb_push(1);
    train_detected[2] = 1'b1;
    @(negedge clk);
    sb_check("s2b_warn_state", 32'(st(2)));
    sb_push(100); dwell(2, 3'd1, n); sb_check("s2_warn_len_x2", n);
    train_detected[2] = 1'b0;

    // Two trains in section.
    do_reset();
    weather_mode = 2'd0;
    pulse_det(0);
    pulse_det(0);
    sb_push(2); sb_check("s3_occ2", 32'(occ(0)));
    wait_state(0, 3'd4, 400, "s3_tp");
    pulse_exit(0);
    repeat (2) @(negedge clk);
    sb_push(1); sb_check("s3_occ1", 32'(occ(0)));
    sb_push(4); sb_check("s3_still_tp", 32'(st(0)));
    pulse_exit(0);
    wait_state(0, 3'd5, 10, "s3_clr");
    sb_push(5); sb_check("s3_clr_state", 32'(st(0)));
    train_detected[0] = 1'b1;
    @(negedge clk);
    sb_push(4); sb_check("s3_retrigger", 32'(st(0)));
    sb_push(1); sb_check("s3_barrier", 32'(barrier_down[0]));
    train_detected[0] = 1'b0;
    @(negedge clk);
    sb_push(1); sb_check("s3_occ_re", 32'(occ(0)));

    // No barrier feedback.
    do_reset();
    barrier_down_fb = '0;
    pulse_det(0);
    wait_state(0, 3'd3, 300, "s4_low");
`ifdef BARRIER_FB_CHECK_EN
    sb_push(64); dwell(0, 3'd3, n); sb_check("s4_timeout_len", n);
    sb_push(7);  sb_check("s4_fault_state", 32'(st(0)));
    sb_push(1);  sb_check("s4_bfault", 32'(barrier_faults[0]));
    sb_push(1);  sb_check("s4_barrier", 32'(barrier_down[0]));
    sb_push(1);  sb_check("s4_alarm", 32'(alarm_sound[0]));
    pulse_exit(0);
    sb_push(0);  sb_check("s4_occ0", 32'(occ(0)));
    maint_req[0] = 1'b1;
    @(negedge clk);
    maint_req[0] = 1'b0;
    sb_push(0);  sb_check("s4_maint_idle", 32'(st(0)));
    sb_push(0);  sb_check("s4_bfault_clr", 32'(barrier_faults));
`else
    sb_push(20); dwell(0, 3'd3, n); sb_check("s4_low_len", n);
    sb_push(4);  sb_check("s4_tp_state", 32'(st(0)));
    sb_push(0);  sb_check("s4_bfault_tied", 32'(barrier_faults));
`endif
    sb_push(0);  sb_check("s4_sfault", 32'(sensor_faults));
    barrier_down_fb = '1;

    // Sensor health drop on crossing 1 only.
    do_reset();
    train_detected = '1;
    @(negedge clk);
    sensor_health[1] = 1'b0;
    @(negedge clk);
    sb_push(7);       sb_check("s5_c1_fault", 32'(st(1)));
    sb_push(4'b0010); sb_check("s5_sfaults", 32'(sensor_faults));
    sb_push(1);       sb_check("s5_c0_warn", 32'(st(0)));
    sb_push(1);       sb_check("s5_c2_warn", 32'(st(2)));
    sb_push(1);       sb_check("s5_c3_warn", 32'(st(3)));
    sb_push(4'b0010); sb_check("s5_barrier", 32'(barrier_down));
    sensor_health  = '1;
    train_detected = '0;

    // Global emergency during countdown.
    do_reset();
    train_detected = 4'b0011;
    @(negedge clk);
    train_detected = '0;
    wait_state(0, 3'd2, 100, "s6_cd");
    emergency_global = 1'b1;
    @(negedge clk);
    sb_push(32'hDB6); sb_check("s6_all_emerg", 32'(crossing_states));
    sb_push(4'hF);    sb_check("s6_red", 32'(red_light));
    sb_push(4'hF);    sb_check("s6_alarm", 32'(alarm_sound));
    train_detected[0] = 1'b1;
    train_exited[0]   = 1'b1;
    train_exited[2]   = 1'b1;
    @(negedge clk);
    sb_push(1); sb_check("s6_simul_rise", 32'(occ(0)));
    sb_push(0); sb_check("s6_no_underflow", 32'(occ(2)));
    train_detected = '0;
    train_exited   = '0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) pulse_det(3);
    sb_push(7); sb_check("s6_occ_sat", 32'(occ(3)));
    emergency_global = 1'b0;
    @(negedge clk);
    sb_push(32'h61B); sb_check("s6_release", 32'(crossing_states));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
